// File: rtl/machine_dispatch_pkg.sv
// Shared definitions for the Machine dispatcher: slot tags, operation kinds,
// parameter defaults and the sequencer state encoding.
package machine_pkg;
   localparam int DATA_W_DEF    = 63;
   localparam int WB_W_DEF      = 95;
   localparam int STALL_MAX_DEF = 255;

   localparam logic [1:0] TAG_NONE = 2'b00;
   localparam logic [1:0] TAG_PEND = 2'b01;

   localparam logic [1:0] KIND_NOP    = 2'b00;
   localparam logic [1:0] KIND_UNARY  = 2'b01;
   localparam logic [1:0] KIND_BINARY = 2'b10;

   typedef enum logic [1:0] {IDLE, CHECK, ISSUE} state_t;

   // Tags 10 and 11 both carry a value.
   function automatic logic tag_present(input logic [1:0] tag);
      return tag[1];
   endfunction
endpackage

// File: rtl/machine_dispatch_if.sv
// Decode/write-back/execute bundle seen by the dispatcher.
interface machine_dispatch_if
   import machine_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int WB_W    = WB_W_DEF,
   parameter int STALL_W = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_W+1:0]     in_r1;
   logic [DATA_W+1:0]     in_r2;
   logic [WB_W-1:0]       wb_w1;
   logic [WB_W-1:0]       wb_w2;
   logic                  opnd_upd;
   logic [DATA_W+1:0]     opnd_r1;
   logic [DATA_W+1:0]     opnd_r2;
   logic                  op_valid;
   logic                  op_ready;
   logic [2*DATA_W+1:0]   op_data;
   logic [STALL_W-1:0]    stall_cnt;
   logic                  timeout;

   modport master (
      output in_valid, in_r1, in_r2, wb_w1, wb_w2, opnd_upd, opnd_r1, opnd_r2, op_ready,
      input  in_ready, op_valid, op_data, stall_cnt, timeout
   );
   modport slave (
      input  in_valid, in_r1, in_r2, wb_w1, wb_w2, opnd_upd, opnd_r1, opnd_r2, op_ready,
      output in_ready, op_valid, op_data, stall_cnt, timeout
   );
endinterface

// File: rtl/machine_dispatch_check.sv
// Combinational operand check: decides whether the latched instruction may
// issue and forms the {kind, v1, v2} operation word.
module machine_dispatch_check
   import machine_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W+1:0]   r1,
   input  logic [DATA_W+1:0]   r2,
   input  logic [1:0]          w1_tag,
   input  logic [1:0]          w2_tag,
   output logic                blocked,
   output logic [2*DATA_W+1:0] op_data
);
   logic [1:0] t1, t2;
   logic       p1, p2;

   assign t1 = r1[DATA_W+1:DATA_W];
   assign t2 = r2[DATA_W+1:DATA_W];
   assign p1 = tag_present(t1);
   assign p2 = tag_present(t2);

   // r2 without r1 is an illegal encoding; hold it like any other stall.
   assign blocked = (w1_tag == TAG_PEND) || (w2_tag == TAG_PEND) || (t1 == TAG_PEND) ||
                    (p1 && t2 == TAG_PEND) || (!p1 && p2);

   always_comb begin
      op_data = '0;
      if (p1 && p2)
         op_data = {KIND_BINARY, r1[DATA_W-1:0], r2[DATA_W-1:0]};
      else if (p1)
         op_data = {KIND_UNARY, r1[DATA_W-1:0], {DATA_W{1'b0}}};
   end
endmodule

// File: rtl/machine_dispatch.sv
// One-deep dispatcher: latch instruction, wait out hazards with stall
// accounting, then hold the operation on a valid/ready handshake.
module machine_dispatch
   import machine_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int WB_W      = WB_W_DEF,
   parameter int STALL_MAX = STALL_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   machine_dispatch_if.slave bus
);
   localparam int STALL_W = $clog2(STALL_MAX + 1);

   state_t              state;
   logic [DATA_W+1:0]   r1, r2;
   logic                blocked;
   logic [2*DATA_W+1:0] chk_data;

   machine_dispatch_check #(.DATA_W(DATA_W)) u_check (
      .r1      (r1),
      .r2      (r2),
      .w1_tag  (bus.wb_w1[WB_W-1:WB_W-2]),
      .w2_tag  (bus.wb_w2[WB_W-1:WB_W-2]),
      .blocked (blocked),
      .op_data (chk_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         r1            <= '0;
         r2            <= '0;
         bus.in_ready  <= 1'b1;
         bus.op_valid  <= 1'b0;
         bus.op_data   <= '0;
         bus.stall_cnt <= '0;
         bus.timeout   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               r1            <= bus.in_r1;
               r2            <= bus.in_r2;
               bus.in_ready  <= 1'b0;
               bus.stall_cnt <= '0;
               state         <= CHECK;
            end
            CHECK: if (blocked) begin
               if (bus.stall_cnt != STALL_W'(STALL_MAX))
                  bus.stall_cnt <= bus.stall_cnt + 1'b1;
               if (bus.stall_cnt == STALL_W'(STALL_MAX - 1))
                  bus.timeout <= 1'b1;
               if (bus.opnd_upd) begin
                  r1 <= bus.opnd_r1;
                  r2 <= bus.opnd_r2;
               end
            end else begin
               bus.op_valid <= 1'b1;
               bus.op_data  <= chk_data;
               state        <= ISSUE;
            end
            ISSUE: if (bus.op_ready) begin
               bus.op_valid  <= 1'b0;
               bus.in_ready  <= 1'b1;
               bus.stall_cnt <= '0;
               bus.timeout   <= 1'b0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_machine_dispatch.sv
// Scenario bench for machine_dispatch with a queue of expected operations.
module tb_machine_dispatch;
   import machine_pkg::*;

   localparam int DW = 63;
   localparam int WW = 95;
   localparam int SM = 8;
   localparam int SW = $clog2(SM + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   logic [2*DW+1:0] exp_q[$];
   logic [2*DW+1:0] exp;

   machine_dispatch_if #(.DATA_W(DW), .WB_W(WW), .STALL_W(SW)) bus ();
   machine_dispatch #(.DATA_W(DW), .WB_W(WW), .STALL_MAX(SM)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   function automatic logic [DW+1:0] slot(input logic [1:0] tag, input logic [DW-1:0] v);
      return {tag, v};
   endfunction

   // Reference operation word from the slot table.
   function automatic logic [2*DW+1:0] model_op(input logic [DW+1:0] a, input logic [DW+1:0] b);
      logic pa, pb;
      pa = a[DW+1];
      pb = b[DW+1];
      if (pa && pb) return {2'b10, a[DW-1:0], b[DW-1:0]};
      if (pa)       return {2'b01, a[DW-1:0], {DW{1'b0}}};
      return '0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW+1:0] a, input logic [DW+1:0] b, input logic push);
      bus.in_valid = 1'b1;
      bus.in_r1    = a;
      bus.in_r2    = b;
      if (push) exp_q.push_back(model_op(a, b));
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output int n);
      n = 0;
      while (!bus.op_valid && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic pop_exp();
      if (exp_q.size() == 0) exp = 'x;
      else exp = exp_q.pop_front();
   endtask

   task automatic test_reset();
      tick(); tick();
      n_chk++; if (bus.op_valid !== 1'b0) begin n_fail++; $display("FAIL reset op_valid: got %b want 0", bus.op_valid); end
      n_chk++; if (bus.op_data !== '0) begin n_fail++; $display("FAIL reset op_data: got %h want 0", bus.op_data); end
      rst = 1'b0;
      tick();
      n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
      n_chk++; if (bus.stall_cnt !== '0 || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL reset stall: got %0d/%b want 0/0", bus.stall_cnt, bus.timeout); end
   endtask

   task automatic test_binary();
      int n;
      send(slot(2'b10, 63'h5), slot(2'b10, 63'h9), 1'b1);
      n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL binary in_ready: got %b want 0", bus.in_ready); end
      wait_valid(20, n);
      n_chk++; if (n + 1 !== 2) begin n_fail++; $display("FAIL binary latency: got %0d want 2", n + 1); end
      pop_exp();
      n_chk++; if (bus.op_data !== exp) begin n_fail++; $display("FAIL binary data: got %h want %h", bus.op_data, exp); end
      n_chk++; if (bus.stall_cnt !== '0) begin n_fail++; $display("FAIL binary stall: got %0d want 0", bus.stall_cnt); end
      tick();
   endtask

   task automatic test_kinds();
      int n;
      send(slot(2'b10, 63'h7), slot(2'b00, 63'h1234), 1'b1);
      wait_valid(20, n);
      pop_exp();
      n_chk++; if (bus.op_data !== exp || exp[2*DW+1:2*DW] !== KIND_UNARY) begin n_fail++; $display("FAIL unary data: got %h want %h", bus.op_data, exp); end
      tick();
      send(slot(2'b00, 63'h3), slot(2'b00, 63'h4), 1'b1);
      wait_valid(20, n);
      pop_exp();
      n_chk++; if (bus.op_valid !== 1'b1 || bus.op_data !== exp) begin n_fail++; $display("FAIL nop data: got %b/%h want 1/%h", bus.op_valid, bus.op_data, exp); end
      tick();
   endtask

   task automatic test_wb_stall();
      int n;
      bus.wb_w1 = {2'b01, 93'h0};
      send(slot(2'b11, 63'h11), slot(2'b10, 63'h22), 1'b1);
      repeat (4) tick();
      n_chk++; if (bus.op_valid !== 1'b0 || bus.stall_cnt !== SW'(4)) begin n_fail++; $display("FAIL wb_stall hold: got %b/%0d want 0/4", bus.op_valid, bus.stall_cnt); end
      bus.wb_w1 = '0;
      wait_valid(20, n);
      pop_exp();
      n_chk++; if (n !== 1 || bus.op_data !== exp) begin n_fail++; $display("FAIL wb_stall issue: got n=%0d %h want n=1 %h", n, bus.op_data, exp); end
      n_chk++; if (bus.stall_cnt !== SW'(4) || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL wb_stall cnt: got %0d/%b want 4/0", bus.stall_cnt, bus.timeout); end
      tick();
   endtask

   task automatic test_opnd_upd();
      int n;
      send(slot(2'b10, 63'h1), slot(2'b01, 63'h0), 1'b0);
      exp_q.push_back({2'b10, 63'h1, 63'h3});
      repeat (5) tick();
      bus.opnd_upd = 1'b1;
      bus.opnd_r1  = slot(2'b10, 63'h1);
      bus.opnd_r2  = slot(2'b11, 63'h3);
      tick();
      bus.opnd_upd = 1'b0;
      n_chk++; if (bus.op_valid !== 1'b0 || bus.stall_cnt !== SW'(6)) begin n_fail++; $display("FAIL upd hold: got %b/%0d want 0/6", bus.op_valid, bus.stall_cnt); end
      wait_valid(20, n);
      pop_exp();
      n_chk++; if (n !== 1 || bus.op_data !== exp) begin n_fail++; $display("FAIL upd issue: got n=%0d %h want n=1 %h", n, bus.op_data, exp); end
      tick();
   endtask

   task automatic test_timeout();
      int n;
      bus.wb_w2 = {2'b01, 93'h5};
      send(slot(2'b10, 63'hA), slot(2'b10, 63'hB), 1'b1);
      repeat (20) tick();
      n_chk++; if (bus.stall_cnt !== SW'(SM) || bus.timeout !== 1'b1 || bus.op_valid !== 1'b0) begin n_fail++; $display("FAIL timeout sat: got %0d/%b/%b want 8/1/0", bus.stall_cnt, bus.timeout, bus.op_valid); end
      bus.wb_w2 = '0;
      wait_valid(20, n);
      pop_exp();
      n_chk++; if (bus.op_data !== exp || bus.timeout !== 1'b1) begin n_fail++; $display("FAIL timeout issue: got %h/%b want %h/1", bus.op_data, bus.timeout, exp); end
      tick();
      n_chk++; if (bus.stall_cnt !== '0 || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL timeout clear: got %0d/%b want 0/0", bus.stall_cnt, bus.timeout); end
   endtask

   task automatic test_backpressure();
      int n;
      bus.op_ready = 1'b0;
      send(slot(2'b10, 63'h1F), slot(2'b11, 63'h2E), 1'b1);
      wait_valid(20, n);
      pop_exp();
      bus.in_valid = 1'b1;
      bus.in_r1    = slot(2'b10, 63'h77);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_chk++; if (bus.op_valid !== 1'b1 || bus.op_data !== exp || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stable[%0d]: got %b/%h want 1/%h", i, bus.op_valid, bus.op_data, exp); end
      end
      bus.in_valid = 1'b0;
      bus.op_ready = 1'b1;
      tick();
      n_chk++; if (bus.op_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release: got %b/%b want 0/1", bus.op_valid, bus.in_ready); end
   endtask

   task automatic test_back_to_back();
      int n;
      for (int k = 0; k < 3; k++) begin
         send(slot(2'b10, DW'($urandom)), slot(2'b10, DW'($urandom)), 1'b1);
         wait_valid(20, n);
         pop_exp();
         n_chk++; if (bus.op_data !== exp) begin n_fail++; $display("FAIL b2b[%0d] data: got %h want %h", k, bus.op_data, exp); end
         tick();
         n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b[%0d] ready: got %b want 1", k, bus.in_ready); end
      end
   endtask

   task automatic test_reset_mid_issue();
      int n;
      bus.op_ready = 1'b0;
      send(slot(2'b10, 63'h5), slot(2'b10, 63'h6), 1'b0);
      wait_valid(20, n);
      #2 rst = 1'b1;
      #1;
      n_chk++; if (bus.op_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid async: got %b/%b want 0/1", bus.op_valid, bus.in_ready); end
      tick();
      rst = 1'b0;
      bus.op_ready = 1'b1;
      n = 0;
      repeat (4) begin tick(); if (bus.op_valid) n++; end
      n_chk++; if (n !== 0) begin n_fail++; $display("FAIL rst_mid reissue: got %0d valid cycles want 0", n); end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_r1    = '0;
      bus.in_r2    = '0;
      bus.wb_w1    = '0;
      bus.wb_w2    = '0;
      bus.opnd_upd = 1'b0;
      bus.opnd_r1  = '0;
      bus.opnd_r2  = '0;
      bus.op_ready = 1'b1;
      test_reset();
      test_binary();
      test_kinds();
      test_wb_stall();
      test_opnd_upd();
      test_timeout();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_issue();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
